// File: rtl/mbc_sram_arbiter.sv
// Cartridge save-SRAM arbiter: GB bus (priority) and host port share one async SRAM.
// GB strobes are synchronised and serviced once per strobe; the host fills idle gaps.
// Optional feature: define ARB_WAIT_CNT_EN to add the HOST_WAIT_CNT saturating wait counter.
module mbc_sram_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned ACCESS_CYC  = 3,
  parameter int unsigned RECOVER_CYC = 1
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              GB_RAM_SEL,
  input  logic              GB_RD,
  input  logic              GB_WR,
  input  logic [ADDR_W-1:0] GB_ADDR,
  input  logic [7:0]        GB_WDATA,
  output logic [7:0]        GB_RDATA,
  output logic              GB_RDATA_VLD,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [7:0]        HOST_WDATA,
  output logic [7:0]        HOST_RDATA,
  output logic              HOST_ACK,
`ifdef ARB_WAIT_CNT_EN
  output logic [15:0]       HOST_WAIT_CNT,
`endif
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [7:0]        SRAM_DQ_IN,
  output logic [7:0]        SRAM_DQ_OUT,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  typedef enum logic [2:0] {
    StIdle, StGbRd, StGbWr, StHostRd, StHostWr, StRecover
  } state_t;

  localparam logic [15:0] AccLast = 16'(ACCESS_CYC - 1);
  localparam logic [15:0] RecLast = 16'(RECOVER_CYC - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        armed_q;
  logic        sel_s1, sel_s2, rd_s1, rd_s2, wr_s1, wr_s2;
  logic        gb_rd_go, gb_wr_go;

  // Two-flop synchronisers for the asynchronous GB strobes (strobes idle high)
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
      rd_s1  <= 1'b1;
      rd_s2  <= 1'b1;
      wr_s1  <= 1'b1;
      wr_s2  <= 1'b1;
    end else begin
      sel_s1 <= GB_RAM_SEL;
      sel_s2 <= sel_s1;
      rd_s1  <= GB_RD;
      rd_s2  <= rd_s1;
      wr_s1  <= GB_WR;
      wr_s2  <= wr_s1;
    end
  end

  assign gb_rd_go = sel_s2 & ~rd_s2;
  assign gb_wr_go = sel_s2 & ~wr_s2;

  // Arbitration FSM with registered SRAM strobes and result registers
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      armed_q      <= 1'b1;
      SRAM_ADDR    <= '0;
      SRAM_DQ_OUT  <= '0;
      SRAM_DQ_OE   <= 1'b0;
      SRAM_CE_N    <= 1'b1;
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      GB_RDATA     <= '0;
      GB_RDATA_VLD <= 1'b0;
      HOST_RDATA   <= '0;
      HOST_ACK     <= 1'b0;
    end else begin
      HOST_ACK <= 1'b0;
      // Re-arm once the GB has released both strobes
      if (rd_s2 && wr_s2) armed_q <= 1'b1;
      // Valid drops when the GB ends its read; a fresh sample below overrides
      if (GB_RDATA_VLD && rd_s2) GB_RDATA_VLD <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (armed_q && gb_rd_go) begin
            state_q   <= StGbRd;
            armed_q   <= 1'b0;
            SRAM_ADDR <= GB_ADDR;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= 1'b0;
          end else if (armed_q && gb_wr_go) begin
            state_q     <= StGbWr;
            armed_q     <= 1'b0;
            SRAM_ADDR   <= GB_ADDR;
            SRAM_DQ_OUT <= GB_WDATA;
            SRAM_DQ_OE  <= 1'b1;
            SRAM_CE_N   <= 1'b0;
            SRAM_WE_N   <= 1'b0;
          end else if (HOST_REQ) begin
            SRAM_ADDR <= HOST_ADDR;
            SRAM_CE_N <= 1'b0;
            if (HOST_WE) begin
              state_q     <= StHostWr;
              SRAM_DQ_OUT <= HOST_WDATA;
              SRAM_DQ_OE  <= 1'b1;
              SRAM_WE_N   <= 1'b0;
            end else begin
              state_q   <= StHostRd;
              SRAM_OE_N <= 1'b0;
            end
          end
        end
        StGbRd, StGbWr, StHostRd, StHostWr: begin
          if (cnt_q == AccLast) begin
            state_q    <= StRecover;
            cnt_q      <= '0;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            if (state_q == StGbRd) begin
              GB_RDATA     <= SRAM_DQ_IN;
              GB_RDATA_VLD <= 1'b1;
            end
            if (state_q == StHostRd) HOST_RDATA <= SRAM_DQ_IN;
            if (state_q == StHostRd || state_q == StHostWr) HOST_ACK <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StRecover: begin
          if (cnt_q == RecLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_WAIT_CNT_EN
  logic host_rec_q;
  logic host_busy;

  assign host_busy = (state_q == StHostRd) || (state_q == StHostWr) ||
                     ((state_q == StRecover) && host_rec_q);

  // Remember whether the current RECOVER follows a host access; count host wait cycles
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      host_rec_q    <= 1'b0;
      HOST_WAIT_CNT <= '0;
    end else begin
      if (state_q == StHostRd || state_q == StHostWr) host_rec_q <= 1'b1;
      else if (state_q != StRecover) host_rec_q <= 1'b0;
      if (HOST_REQ && !host_busy && HOST_WAIT_CNT != 16'hFFFF)
        HOST_WAIT_CNT <= HOST_WAIT_CNT + 16'd1;
    end
  end
`endif

endmodule
